// File: rtl/dm_access_unit_if.sv
// ----------------------------------------------------------------------------
// dm_access_unit_if
//   Bundles the CPU request/response handshake and the BlockRAM port of the
//   data-memory access unit.
//
//   Request  : req_valid, req_ready, req_we, req_size, req_signed, req_addr,
//              req_wdata
//   Response : resp_valid, resp_ready, resp_rdata, resp_exc
//   RAM port : mem_addr (ADDR_BITS word address), mem_wea (byte write enables),
//              mem_dina (write data), mem_douta (read data)
//
//   modport slave  : the access unit itself
//   modport master : its environment (MEM pipeline stage plus the RAM wrapper)
// ----------------------------------------------------------------------------
interface dm_access_unit_if #(
  parameter int ADDR_BITS = 13
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_signed;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [31:0]          resp_rdata;
  logic                 resp_exc;

  logic [ADDR_BITS-1:0] mem_addr;
  logic [3:0]           mem_wea;
  logic [31:0]          mem_dina;
  logic [31:0]          mem_douta;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_douta,
    output req_ready, resp_valid, resp_rdata, resp_exc,
    output mem_addr, mem_wea, mem_dina
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_douta,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
    input  mem_addr, mem_wea, mem_dina
  );
endinterface

// File: rtl/dm_access_unit.sv
// ----------------------------------------------------------------------------
// dm_access_unit
//   CPU-side initiator for the data-memory BlockRAM port. Accepts one
//   load/store at a time, drives the registered RAM address / byte enables /
//   replicated write data, and for loads waits the RAM read latency before
//   selecting and sign/zero-extending the addressed byte or half.
//
// Parameters
//   ADDR_BITS  : word-address width to the RAM (byte address [ADDR_BITS+1:2])
//   RD_LATENCY : cycles from mem_addr valid to mem_douta valid, 1..3
//
// Ports
//   clk   : clock, all logic on posedge
//   reset : asynchronous, active-high; returns to IDLE and clears all outputs
//   bus   : dm_access_unit_if.slave (request, response and RAM port)
//
// Configuration macro
//   DM_MISALIGN_EXC_EN : when defined, misaligned half/word accesses are
//   rejected with resp_exc; otherwise the offending low address bits are
//   cleared and the access proceeds.
// ----------------------------------------------------------------------------
module dm_access_unit #(
  parameter int ADDR_BITS  = 13,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  dm_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_n;
  logic [1:0]           cnt, cnt_n;
  logic                 we_q, we_n;
  logic [1:0]           size_q, size_n;
  logic                 sgn_q, sgn_n;
  logic [1:0]           off_q, off_n;
  logic [ADDR_BITS-1:0] addr_q, addr_n;
  logic [3:0]           wea_q, wea_n;
  logic [31:0]          dina_q, dina_n;
  logic                 resp_valid_q, resp_valid_n;
  logic [31:0]          rdata_q, rdata_n;
  logic                 exc_q, exc_n;

  logic                 accept;
  logic                 reject;
  logic [1:0]           req_off;
  logic                 unused_addr_hi;

  function automatic logic [3:0] store_wea(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    store_wea = 4'b0001 << off;
      2'd1:    store_wea = off[1] ? 4'b1100 : 4'b0011;
      2'd2:    store_wea = 4'b1111;
      default: store_wea = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_dina(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    store_dina = {4{wdata[7:0]}};
      2'd1:    store_dina = {2{wdata[15:0]}};
      default: store_dina = wdata;
    endcase
  endfunction

  // off is already aligned for halves, so a shift of 8*off also selects the half.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] size,
                                              input logic sgn, input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
      2'd1:    load_extend = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: load_extend = w;
    endcase
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd1:    align_off = {off[1], 1'b0};
      2'd2:    align_off = 2'b00;
      default: align_off = off;
    endcase
  endfunction

  // Address bits above the RAM window are deliberately ignored (wrap-around).
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_BITS+2];

  assign accept = bus.req_valid && (state == IDLE);

`ifdef DM_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
  assign reject  = (bus.req_size == 2'd3) || misaligned;
  assign req_off = bus.req_addr[1:0];
`else
  assign reject  = (bus.req_size == 2'd3);
  assign req_off = align_off(bus.req_size, bus.req_addr[1:0]);
`endif

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    we_n         = we_q;
    size_n       = size_q;
    sgn_n        = sgn_q;
    off_n        = off_q;
    addr_n       = addr_q;
    wea_n        = wea_q;
    dina_n       = dina_q;
    resp_valid_n = resp_valid_q;
    rdata_n      = rdata_q;
    exc_n        = exc_q;

    case (state)
      IDLE: begin
        if (accept) begin
          we_n   = bus.req_we;
          size_n = bus.req_size;
          sgn_n  = bus.req_signed;
          off_n  = req_off;
          if (reject) begin
            // Rejected requests answer straight away and never touch the RAM.
            exc_n        = 1'b1;
            rdata_n      = 32'h0;
            resp_valid_n = 1'b1;
            state_n      = RESP;
          end else begin
            exc_n   = 1'b0;
            addr_n  = bus.req_addr[ADDR_BITS+1:2];
            dina_n  = store_dina(bus.req_size, bus.req_wdata);
            wea_n   = bus.req_we ? store_wea(bus.req_size, req_off) : 4'b0000;
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        wea_n = 4'b0000;
        if (we_q) begin
          rdata_n      = 32'h0;
          resp_valid_n = 1'b1;
          state_n      = RESP;
        end else begin
          cnt_n   = 2'(RD_LATENCY - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          rdata_n      = load_extend(bus.mem_douta, size_q, sgn_q, off_q);
          resp_valid_n = 1'b1;
          state_n      = RESP;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sgn_q        <= 1'b0;
      off_q        <= 2'd0;
      addr_q       <= '0;
      wea_q        <= 4'b0000;
      dina_q       <= 32'h0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      exc_q        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      we_q         <= we_n;
      size_q       <= size_n;
      sgn_q        <= sgn_n;
      off_q        <= off_n;
      addr_q       <= addr_n;
      wea_q        <= wea_n;
      dina_q       <= dina_n;
      resp_valid_q <= resp_valid_n;
      rdata_q      <= rdata_n;
      exc_q        <= exc_n;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_exc   = exc_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wea    = wea_q;
  assign bus.mem_dina   = dina_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// ----------------------------------------------------------------------------
// tb_dm_access_unit
//   Bench for dm_access_unit. A RAM model sits on each RAM port; a separate
//   reference memory tracks expected contents. Expected responses go into a
//   queue when a request is driven and are compared when the response is
//   consumed. A second instance with RD_LATENCY=3 runs alongside for the
//   latency comparison. Honours DM_MISALIGN_EXC_EN like the design.
// ----------------------------------------------------------------------------
module tb_dm_access_unit;

  localparam int RD3 = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        exc;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  logic ram_load;

  dm_access_unit_if #(.ADDR_BITS(13)) bus ();
  dm_access_unit_if #(.ADDR_BITS(13)) bus3 ();

  dm_access_unit #(.ADDR_BITS(13), .RD_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dm_access_unit #(.ADDR_BITS(13), .RD_LATENCY(RD3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  exp_t        exp_q[$];
  logic [31:0] mdl [16];
  logic [31:0] ram1 [16];
  logic [31:0] ram3 [16];
  logic [3:0]  a3_1, a3_2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h80F0_1234;
    return 32'h9E37_79B9 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // RAM with one cycle read latency
  always @(posedge clk) begin : ram1_blk
    logic [31:0] w;
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram1[i] <= init_word(i);
    end else begin
      w = ram1[bus.mem_addr[3:0]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wea[b]) w[8*b +: 8] = bus.mem_dina[8*b +: 8];
      ram1[bus.mem_addr[3:0]] <= w;
    end
    bus.mem_douta <= ram1[bus.mem_addr[3:0]];
  end

  // RAM with three cycle read latency
  always @(posedge clk) begin : ram3_blk
    logic [31:0] w;
    if (ram_load) begin
      for (int i = 0; i < 16; i++) ram3[i] <= init_word(i);
    end else begin
      w = ram3[bus3.mem_addr[3:0]];
      for (int b = 0; b < 4; b++)
        if (bus3.mem_wea[b]) w[8*b +: 8] = bus3.mem_dina[8*b +: 8];
      ram3[bus3.mem_addr[3:0]] <= w;
    end
    a3_1 <= bus3.mem_addr[3:0];
    a3_2 <= a3_1;
    bus3.mem_douta <= ram3[a3_2];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard for the RD_LATENCY=1 instance
  int          acc_n = 0;
  int          rise_c = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_rdata = 32'h0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.req_valid && bus.req_ready) acc_n = cyc + 1;
    if (bus.resp_valid && !prev_valid) rise_c = cyc;
    if (prev_valid && !prev_ready && !reset) begin
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, prev_rdata);
    end
    if (bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rdata", bus.resp_rdata, e.rdata);
        chk("sb_exc", 32'(bus.resp_exc), 32'(e.exc));
        chk("sb_latency", 32'(rise_c + 1 - acc_n), 32'(e.lat));
      end
    end
    prev_valid = reset ? 1'b0 : bus.resp_valid;
    prev_ready = bus.resp_ready;
    prev_rdata = bus.resp_rdata;
  end

  task automatic idle_bus();
    bus.req_valid  = 1'b0; bus.req_we   = 1'b0; bus.req_size  = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    bus3.req_valid  = 1'b0; bus3.req_we   = 1'b0; bus3.req_size  = 2'd0;
    bus3.req_signed = 1'b0; bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0;
    bus3.resp_ready = 1'b0;
  endtask

  // One complete transaction on the RD_LATENCY=1 instance. hold = cycles the
  // response is left waiting; poke = offer a competing store while it waits.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit poke);
    logic [1:0]  a;
    logic        exc;
    logic [3:0]  wea;
    logic [31:0] dina, w, rd;
    logic [7:0]  bt;
    logic [15:0] hw;
    logic [12:0] maddr;
    exp_t        e;
    int          t;
    bit          got;

    a = addr[1:0];
    exc = (size == 2'd3);
`ifdef DM_MISALIGN_EXC_EN
    if ((size == 2'd1 && a[0]) || (size == 2'd2 && a != 2'b00)) exc = 1'b1;
`else
    if (size == 2'd1) a[0] = 1'b0;
    if (size == 2'd2) a = 2'b00;
`endif
    maddr = addr[14:2];
    wea = 4'b0000; dina = 32'h0; rd = 32'h0;
    if (!exc) begin
      w = mdl[maddr[3:0]];
      case (size)
        2'd0: begin
          dina = {4{wdata[7:0]}}; wea = 4'b0001 << a;
          bt = w[8*a +: 8];
          rd = sgn ? {{24{bt[7]}}, bt} : {24'h0, bt};
        end
        2'd1: begin
          dina = {2{wdata[15:0]}}; wea = a[1] ? 4'b1100 : 4'b0011;
          hw = w[16*a[1] +: 16];
          rd = sgn ? {{16{hw[15]}}, hw} : {16'h0, hw};
        end
        default: begin
          dina = wdata; wea = 4'b1111; rd = w;
        end
      endcase
      if (we) begin
        for (int b = 0; b < 4; b++) if (wea[b]) w[8*b +: 8] = dina[8*b +: 8];
        mdl[maddr[3:0]] = w;
        rd = 32'h0;
      end
    end
    e.rdata = rd;
    e.exc   = exc;
    e.lat   = exc ? 1 : (we ? 2 : 3);

    t = 0;
    while (!bus.req_ready && t < 10) begin @(posedge clk); #1; t++; end
    if (!bus.req_ready) begin
      chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
      return;
    end
    exp_q.push_back(e);
    bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (exc) begin
      chk("wea_rejected", 32'(bus.mem_wea), 32'd0);
    end else begin
      chk("issue_wea", 32'(bus.mem_wea), we ? 32'(wea) : 32'd0);
      chk("issue_addr", 32'(bus.mem_addr), 32'(maddr));
      if (we) chk("issue_dina", bus.mem_dina, dina);
    end
    @(posedge clk); #1;
    chk("wea_after_issue", 32'(bus.mem_wea), 32'd0);

    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
    end
    if (!got) begin
      chk("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke) begin
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h24;
        bus.req_wdata = 32'hDEAD_BEEF; bus.req_valid = 1'b1;
        chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
        chk("busy_wea", 32'(bus.mem_wea), 32'd0);
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_dropped", 32'(bus.resp_valid), 32'd0);
    chk("ready_again", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int k1, k3;
    exp_t e;
    clk = 1'b0; reset = 1'b1; ram_load = 1'b1;
    idle_bus();
    for (int i = 0; i < 16; i++) mdl[i] = init_word(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wea", 32'(bus.mem_wea), 32'd0);
    chk("rst_mem_dina", bus.mem_dina, 32'd0);
    ram_load = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    // byte store to the top lane, read back through the RAM
    do_req(1'b1, 2'd0, 1'b0, 32'h0000_0003, 32'h0000_00A5, 0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 0, 1'b0);

    // extraction / extension from 0x80F01234 at 0x10
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 2, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b1, 32'hABCD_0010, 32'h0, 0, 1'b0);

    // RD_LATENCY=1 and RD_LATENCY=3 side by side on the same load
    e.rdata = mdl[4]; e.exc = 1'b0; e.lat = 3;
    exp_q.push_back(e);
    bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0; bus.req_addr = 32'h10;
    bus3.req_we = 1'b0; bus3.req_size = 2'd2; bus3.req_signed = 1'b0; bus3.req_addr = 32'h10;
    bus.req_valid = 1'b1; bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus3.req_valid = 1'b0;
    k1 = 0; k3 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (k1 == 0 && bus.resp_valid) k1 = i;
      if (k3 == 0 && bus3.resp_valid) k3 = i;
      if (k1 != 0 && k3 != 0) break;
    end
    chk("lat3_cycles", 32'(k3), 32'(2 + RD3));
    chk("lat3_minus_lat1", 32'(k3 - k1), 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lat3_hold_valid", 32'(bus3.resp_valid), 32'd1);
    end
    chk("lat3_rdata", bus3.resp_rdata, 32'h80F0_1234);
    chk("lat3_exc", 32'(bus3.resp_exc), 32'd0);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1; bus3.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0; bus3.resp_ready = 1'b0;
    chk("lat3_dropped", 32'(bus3.resp_valid), 32'd0);
    @(posedge clk); #1;

    // misaligned word store, halfword store and misaligned half load
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'h1122_3344, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h0000_000A, 32'h0000_BEEF, 1, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0000_000B, 32'h0, 0, 1'b0);

    // illegal size, competing request while the response waits, no write
    do_req(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 2, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0024, 32'h0, 0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0);

    // reset while a store is in ISSUE
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h28;
    bus.req_wdata = 32'h5555_AAAA; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_issue_wea", 32'(bus.mem_wea), 32'hF);
    reset = 1'b1;
    #1;
    chk("rst_async_wea", 32'(bus.mem_wea), 32'd0);
    chk("rst_async_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_rst_wea", 32'(bus.mem_wea), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0028, 32'h0, 0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
